// File: rtl/lsu_ctrl.sv
// Load/store unit between a single requester and a word-wide, registered-read data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests instead of masking the low address bits.
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Req,
    input  logic        i_We,
    input  logic [1:0]  i_Size,
    input  logic        i_Unsigned,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WData,
    output logic        o_Ready,
    output logic        o_RValid,
    output logic [31:0] o_RData,
    output logic        o_Done,
    output logic        o_Misaligned,
    output logic        o_MemReadEn,
    output logic        o_MemWriteEn,
    output logic [31:0] o_MemAddrRead,
    output logic [31:0] o_MemAddrWrite,
    output logic [31:0] o_MemDataWrite,
    input  logic [31:0] i_MemDataRead
);

    typedef enum logic [2:0] {IDLE, LD_RD, LD_WAIT, RMW_RD, RMW_WAIT, WR} state_t;

    state_t              state_q;
    logic [1:0]          size_q;
    logic [1:0]          lane_q;
    logic                unsigned_q;
    logic [15:0]         storeData_q;
    logic [ADDR_W-1:0]   index_q;
    logic                rValid_q, done_q, misaligned_q;
    logic [31:0]         rData_q;
    logic                memReadEn_q, memWriteEn_q;
    logic [31:0]         memAddrRead_q, memAddrWrite_q, memDataWrite_q;

    logic [1:0]          reqSize;
    logic [1:0]          reqLane;
    logic                reqMisaligned;
    logic [31:0]         reqIndex;
    logic [7:0]          loadByte;
    logic [15:0]         loadHalf;
    logic [31:0]         loadData_d;
    logic [31:0]         mergeData_d;
    logic                unusedAddrHi;

    assign unusedAddrHi = ^i_Addr[31:ADDR_W+2];
    assign reqIndex     = 32'(i_Addr[ADDR_W+1:2]);

    // Request decode: either flag misalignment or fold it away by masking the lane bits.
    always_comb begin
        reqSize       = i_Size;
        reqLane       = i_Addr[1:0];
        reqMisaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (i_Size)
            2'b01:   reqMisaligned = i_Addr[0];
            2'b10:   reqMisaligned = |i_Addr[1:0];
            2'b11:   reqMisaligned = 1'b1;
            default: reqMisaligned = 1'b0;
        endcase
`else
        if (i_Size == 2'b11) begin
            reqSize = 2'b10;
        end
        if (reqSize == 2'b01) begin
            reqLane[0] = 1'b0;
        end else if (reqSize == 2'b10) begin
            reqLane = 2'b00;
        end
`endif
    end

    assign loadByte = i_MemDataRead[{lane_q, 3'b000} +: 8];
    assign loadHalf = i_MemDataRead[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   loadData_d = {{24{loadByte[7] & ~unsigned_q}}, loadByte};
            2'b01:   loadData_d = {{16{loadHalf[15] & ~unsigned_q}}, loadHalf};
            default: loadData_d = i_MemDataRead;
        endcase
        mergeData_d = i_MemDataRead;
        if (size_q == 2'b00) begin
            mergeData_d[{lane_q, 3'b000} +: 8] = storeData_q[7:0];
        end else begin
            mergeData_d[{lane_q[1], 4'b0000} +: 16] = storeData_q;
        end
    end

    // Pulses default low every cycle; only the states that complete an event raise them.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q        <= IDLE;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            storeData_q    <= 16'h0000;
            index_q        <= '0;
            rValid_q       <= 1'b0;
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            rData_q        <= 32'h0;
            memReadEn_q    <= 1'b0;
            memWriteEn_q   <= 1'b0;
            memAddrRead_q  <= 32'h0;
            memAddrWrite_q <= 32'h0;
            memDataWrite_q <= 32'h0;
        end else begin
            rValid_q     <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_Req) begin
                        if (reqMisaligned) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            size_q      <= reqSize;
                            lane_q      <= reqLane;
                            unsigned_q  <= i_Unsigned;
                            storeData_q <= i_WData[15:0];
                            index_q     <= i_Addr[ADDR_W+1:2];
                            if (!i_We) begin
                                memReadEn_q   <= 1'b1;
                                memAddrRead_q <= reqIndex;
                                state_q       <= LD_RD;
                            end else if (reqSize == 2'b10) begin
                                memWriteEn_q   <= 1'b1;
                                memAddrWrite_q <= reqIndex;
                                memDataWrite_q <= i_WData;
                                state_q        <= WR;
                            end else begin
                                memReadEn_q   <= 1'b1;
                                memAddrRead_q <= reqIndex;
                                state_q       <= RMW_RD;
                            end
                        end
                    end
                end
                LD_RD: begin
                    memReadEn_q <= 1'b0;
                    state_q     <= LD_WAIT;
                end
                LD_WAIT: begin
                    rData_q  <= loadData_d;
                    rValid_q <= 1'b1;
                    state_q  <= IDLE;
                end
                RMW_RD: begin
                    memReadEn_q <= 1'b0;
                    state_q     <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    memWriteEn_q   <= 1'b1;
                    memAddrWrite_q <= 32'(index_q);
                    memDataWrite_q <= mergeData_d;
                    state_q        <= WR;
                end
                WR: begin
                    memWriteEn_q <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Ready        = (state_q == IDLE);
    assign o_RValid       = rValid_q;
    assign o_RData        = rData_q;
    assign o_Done         = done_q;
    assign o_Misaligned   = misaligned_q;
    assign o_MemReadEn    = memReadEn_q;
    assign o_MemWriteEn   = memWriteEn_q;
    assign o_MemAddrRead  = memAddrRead_q;
    assign o_MemAddrWrite = memAddrWrite_q;
    assign o_MemDataWrite = memDataWrite_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 1024-word registered-read memory model.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the trapping variant.
module tb_lsu_ctrl;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Req = 1'b0;
    logic        i_We = 1'b0;
    logic [1:0]  i_Size = 2'b00;
    logic        i_Unsigned = 1'b0;
    logic [31:0] i_Addr = 32'h0;
    logic [31:0] i_WData = 32'h0;
    logic        o_Ready, o_RValid, o_Done, o_Misaligned;
    logic [31:0] o_RData;
    logic        o_MemReadEn, o_MemWriteEn;
    logic [31:0] o_MemAddrRead, o_MemAddrWrite, o_MemDataWrite;
    logic [31:0] i_MemDataRead = 32'h0;

    logic [31:0] memArray [0:1023];
    logic        preloadEn = 1'b0;
    logic [9:0]  preloadAddr = 10'd0;
    logic [31:0] preloadData = 32'h0;

    int vectorCount = 0;
    int missCount = 0;
    int readCount = 0;
    int writeCount = 0;
    int acceptCount = 0;
    int busyReqCount = 0;
    int rValidCount = 0;
    int doneCount = 0;

    lsu_ctrl #(.ADDR_W(10)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_We(i_We), .i_Size(i_Size),
        .i_Unsigned(i_Unsigned), .i_Addr(i_Addr), .i_WData(i_WData),
        .o_Ready(o_Ready), .o_RValid(o_RValid), .o_RData(o_RData), .o_Done(o_Done),
        .o_Misaligned(o_Misaligned), .o_MemReadEn(o_MemReadEn), .o_MemWriteEn(o_MemWriteEn),
        .o_MemAddrRead(o_MemAddrRead), .o_MemAddrWrite(o_MemAddrWrite),
        .o_MemDataWrite(o_MemDataWrite), .i_MemDataRead(i_MemDataRead)
    );

    always #5 i_Clk = ~i_Clk;

    // Memory model: write and registered read on the same edge, read returns the old word.
    always @(posedge i_Clk) begin
        if (preloadEn) memArray[preloadAddr] <= preloadData;
        if (o_MemWriteEn) begin
            memArray[o_MemAddrWrite[9:0]] <= o_MemDataWrite;
            writeCount++;
        end
        if (o_MemReadEn) begin
            i_MemDataRead <= memArray[o_MemAddrRead[9:0]];
            readCount++;
        end
        if (i_Req && o_Ready) acceptCount++;
        if (i_Req && !o_Ready) busyReqCount++;
        if (o_RValid) rValidCount++;
        if (o_Done) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic preloadWord(input logic [9:0] addr, input logic [31:0] data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        @(negedge i_Clk);
        preloadEn = 1'b0;
    endtask

    // Presents one request for one edge, scrambles the inputs, then waits for any completion pulse.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        i_Req = 1'b1; i_We = we; i_Size = size; i_Unsigned = uns; i_Addr = addr; i_WData = wdata;
        @(negedge i_Clk);
        i_Req = 1'b0; i_We = ~we; i_Size = ~size; i_Unsigned = ~uns;
        i_Addr = ~addr; i_WData = ~wdata;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (o_RValid || o_Done || o_Misaligned) begin
                lat = k;
                break;
            end
            @(negedge i_Clk);
        end
    endtask

    initial begin
        int lat;
        int rd0, wr0, dn0, acc0, busy0, rv0;
        repeat (2) @(negedge i_Clk);
        checkOutput("reset ready", {31'b0, o_Ready}, 32'h1);
        checkOutput("reset pulses", {29'b0, o_RValid, o_Done, o_Misaligned}, 32'h0);
        checkOutput("reset enables", {30'b0, o_MemReadEn, o_MemWriteEn}, 32'h0);
        checkOutput("reset rdata", o_RData, 32'h0);
        checkOutput("reset addr/data", o_MemAddrRead | o_MemAddrWrite | o_MemDataWrite, 32'h0);
        i_Rst = 1'b0;
        @(negedge i_Clk);

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
        checkOutput("word store done latency", lat, 32'd1);
        checkOutput("word store done", {31'b0, o_Done}, 32'h1);
        checkOutput("word store addr", o_MemAddrWrite, 32'h4);
        checkOutput("word store mem", memArray[4], 32'hDEADBEEF);
        @(negedge i_Clk);
        checkOutput("done single pulse", {31'b0, o_Done}, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        checkOutput("word load latency", lat, 32'd2);
        checkOutput("word load rvalid", {31'b0, o_RValid}, 32'h1);
        checkOutput("word load data", o_RData, 32'hDEADBEEF);
        checkOutput("word load addr", o_MemAddrRead, 32'h4);
        @(negedge i_Clk);
        checkOutput("rvalid single pulse", {31'b0, o_RValid}, 32'h0);

        preloadWord(10'd4, 32'h80FF7F01);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat);
        checkOutput("signed byte 0x12", o_RData, 32'hFFFFFFFF);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat);
        checkOutput("unsigned byte 0x13", o_RData, 32'h00000080);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat);
        checkOutput("signed byte 0x13", o_RData, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat);
        checkOutput("unsigned byte 0x10", o_RData, 32'h00000001);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat);
        checkOutput("signed half 0x10", o_RData, 32'h00007F01);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat);
        checkOutput("unsigned half 0x12", o_RData, 32'h000080FF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat);
        checkOutput("signed half 0x12", o_RData, 32'hFFFF80FF);

        preloadWord(10'd4, 32'h11223344);
        rd0 = readCount; wr0 = writeCount;
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAA, lat);
        checkOutput("byte rmw done latency", lat, 32'd3);
        checkOutput("byte rmw done", {31'b0, o_Done}, 32'h1);
        checkOutput("byte rmw reads", readCount - rd0, 32'd1);
        checkOutput("byte rmw writes", writeCount - wr0, 32'd1);
        checkOutput("byte rmw mem", memArray[4], 32'h1122AA44);
        checkOutput("rdata held after store", o_RData, 32'hFFFF80FF);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, lat);
        checkOutput("half rmw done latency", lat, 32'd3);
        checkOutput("half rmw mem", memArray[4], 32'hBEEFAA44);

`ifdef LSU_MISALIGN_TRAP_EN
        rd0 = readCount;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat);
        checkOutput("trap latency", lat, 32'd0);
        checkOutput("trap pulse", {31'b0, o_Misaligned}, 32'h1);
        checkOutput("trap ready", {31'b0, o_Ready}, 32'h1);
        checkOutput("trap no rvalid", {31'b0, o_RValid}, 32'h0);
        @(negedge i_Clk);
        checkOutput("trap single pulse", {31'b0, o_Misaligned}, 32'h0);
        checkOutput("trap no read", readCount - rd0, 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat);
        checkOutput("trap size 11", {31'b0, o_Misaligned}, 32'h1);
`else
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat);
        checkOutput("masked word load latency", lat, 32'd2);
        checkOutput("masked word load data", o_RData, 32'hBEEFAA44);
        checkOutput("masked no misalign", {31'b0, o_Misaligned}, 32'h0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h11, 32'h0, lat);
        checkOutput("size 11 as word", o_RData, 32'hBEEFAA44);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat);
        checkOutput("masked half load", o_RData, 32'hFFFFBEEF);
`endif

        preloadWord(10'd8, 32'hCAFEF00D);
        dn0 = doneCount;
        i_Req = 1'b1; i_We = 1'b1; i_Size = 2'b10; i_Addr = 32'h20; i_WData = 32'h55;
        @(negedge i_Clk);
        i_Req = 1'b0;
        checkOutput("in WR before reset", {31'b0, o_MemWriteEn}, 32'h1);
        i_Rst = 1'b1;
        #1;
        checkOutput("reset drops write enable", {31'b0, o_MemWriteEn}, 32'h0);
        checkOutput("reset ready", {31'b0, o_Ready}, 32'h1);
        checkOutput("reset clears rdata", o_RData, 32'h0);
        checkOutput("reset clears write data", o_MemDataWrite, 32'h0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (3) @(negedge i_Clk);
        checkOutput("aborted store mem", memArray[8], 32'hCAFEF00D);
        checkOutput("aborted store no done", doneCount - dn0, 32'd0);

        preloadWord(10'd16, 32'h0);
        acc0 = acceptCount; busy0 = busyReqCount; rv0 = rValidCount; dn0 = doneCount;
        i_Req = 1'b1; i_We = 1'b0; i_Size = 2'b10; i_Unsigned = 1'b0;
        i_Addr = 32'h40; i_WData = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            int a;
            a = acceptCount;
            @(negedge i_Clk);
            if (acceptCount != a) i_We = ~i_We;
        end
        i_Req = 1'b0;
        repeat (4) @(negedge i_Clk);
        checkOutput("b2b accepts", acceptCount - acc0, 32'd4);
        checkOutput("b2b ignored", busyReqCount - busy0, 32'd6);
        checkOutput("b2b rvalid count", rValidCount - rv0, 32'd2);
        checkOutput("b2b done count", doneCount - dn0, 32'd2);
        checkOutput("b2b last load", o_RData, 32'h12345678);
        checkOutput("b2b mem", memArray[16], 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the number of word-address bits driven to the data memory (1024 words).
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_Req, input, 1 bit: access request; accepted on an edge where i_Req=1 and o_Ready=1.
REQ-005 The block SHALL have port i_We, input, 1 bit: 1 selects store, 0 selects load.
REQ-006 The block SHALL have port i_Size, input, 2 bits: 00 selects byte, 01 halfword, 10 word; 11 is reserved.
REQ-007 The block SHALL have port i_Unsigned, input, 1 bit: on loads, 1 zero-extends and 0 sign-extends.
REQ-008 The block SHALL have port i_Addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port i_WData, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have the following requester-side outputs: o_Ready (1 bit, idle and accepting), o_RValid (1 bit, one-cycle load-result pulse), o_RData (32 bits, extended load result), o_Done (1 bit, one-cycle store-complete pulse) and o_Misaligned (1 bit, one-cycle fault pulse).
REQ-011 The block SHALL have the following memory-side ports: o_MemReadEn (out, 1), o_MemWriteEn (out, 1), o_MemAddrRead (out, 32), o_MemAddrWrite (out, 32), o_MemDataWrite (out, 32) and i_MemDataRead (in, 32). The memory returns registered read data in the cycle after the edge on which o_MemReadEn=1.

Function
REQ-012 The block SHALL use FSM states IDLE, LD_RD, LD_WAIT, RMW_RD, RMW_WAIT and WR.
REQ-013 o_Ready SHALL be 1 only in IDLE. i_Req SHALL be ignored in every other state.
REQ-014 The word index SHALL be i_Addr[ADDR_W+1:2], zero-extended to 32 bits on both memory address outputs. The byte lane SHALL be i_Addr[1:0] and the half lane SHALL be i_Addr[1].
REQ-015 All memory-side outputs SHALL be registered. Enables SHALL be 1 only in their own state, and address/data registers SHALL hold their last value otherwise.
REQ-016 Load: accept edge E goes IDLE->LD_RD with o_MemReadEn=1. E+1 goes ->LD_WAIT. E+2 registers the extracted and extended o_RData, pulses o_RValid=1, and goes ->IDLE. o_RValid is therefore high in the cycle after E+2.
REQ-017 Word store: E goes ->WR with o_MemWriteEn=1 and o_MemDataWrite=i_WData. E+1 goes ->IDLE with o_Done=1.
REQ-018 Byte/half store: E goes ->RMW_RD with o_MemReadEn=1. E+1 goes ->RMW_WAIT. E+2 merges the stored byte/half into i_MemDataRead at its lane, leaving the other lanes unchanged, and goes ->WR with o_MemWriteEn=1. E+3 pulses o_Done and goes ->IDLE.
REQ-019 Load extraction: a byte SHALL take bits [8*lane+7:8*lane] and a half SHALL take bits [16*half+15:16*half]. Bit 7 or bit 15 respectively SHALL be replicated into the upper bits unless i_Unsigned=1. Word loads SHALL pass all 32 bits.
REQ-020 i_We, i_Size, i_Unsigned, i_Addr and i_WData SHALL be captured at accept. Changes to these inputs after accept SHALL have no effect.
REQ-021 o_RData SHALL hold its value until the next load completes.
REQ-022 o_RValid, o_Done and o_Misaligned SHALL each be high for exactly one cycle per event.
REQ-023 A new request SHALL be acceptable in the cycle in which o_RValid or o_Done is high (back-to-back operation).

Reset
REQ-024 Asserting i_Rst SHALL immediately force IDLE and drive o_Ready=1, o_RValid=0, o_Done=0, o_Misaligned=0, o_MemReadEn=0, o_MemWriteEn=0, o_RData=0, o_MemAddrRead=0, o_MemAddrWrite=0 and o_MemDataWrite=0.
REQ-025 Reset during any non-IDLE state SHALL abort the operation with no completion pulse. A store pending in WR SHALL NOT be written to memory.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined:
- Misaligned requests are halfword with i_Addr[0]=1, word with i_Addr[1:0]!=00, or i_Size=11.
- A misaligned request SHALL be accepted and then perform no memory access and produce no o_RValid or o_Done.
- o_Misaligned SHALL be 1 in the cycle after the accept edge, and the FSM SHALL stay in IDLE.
REQ-027 With LSU_MISALIGN_TRAP_EN undefined:
- o_Misaligned SHALL be tied to 0.
- Address bits SHALL be masked: [0] for halfword and [1:0] for word.
- i_Size=11 SHALL be treated as a word access.

Verification
REQ-028 Scenario, word store then word load: store 0xDEADBEEF to address 0x10, then load address 0x10 -> o_Done 2 cycles after accept, o_RValid 3 cycles after accept, o_RData=0xDEADBEEF, o_MemAddrWrite=4.
REQ-029 Scenario, signed and unsigned byte loads: with word 4 holding 0x80FF7F01, a signed byte load from 0x12 -> 0xFFFFFFFF, an unsigned byte load from 0x13 -> 0x00000080, a signed half load from 0x10 -> 0x00007F01.
REQ-030 Scenario, byte store RMW: with word 4 holding 0x11223344, store byte 0xAA to 0x11 -> one read then one write of 0x1122AA44, and o_Done 4 cycles after accept.
REQ-031 Scenario, misaligned word load: with the macro defined, a word load at 0x13 -> o_Misaligned pulses once, o_MemReadEn stays 0, o_Ready stays 1. With the macro undefined -> the load reads word 4.
REQ-032 Scenario, reset mid-store: assert i_Rst while in WR during a store of 0x55 to 0x20 -> o_MemWriteEn drops immediately, word 8 is unchanged, there is no o_Done pulse, and o_Ready=1.
REQ-033 Scenario, back-to-back and ignored requests: hold i_Req=1 for 10 cycles with alternating load/store -> exactly one accept per IDLE cycle, and no requests are accepted in LD_RD, LD_WAIT, RMW_RD, RMW_WAIT or WR.
